uart_tx_byte: RTL and testbench
===============================

# uart_tx_byte

Byte-level UART transmitter, 8N1, LSB first. It is the responder to the output FSM: the output FSM raises `transmit` when `tx_idle` is high, and this block serializes the presented byte onto the host serial line. It returns `tx_idle` and a one-cycle `tx_done` so that the output FSM can count bytes and sequence the next load.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per serial bit (50 MHz / 115200). Legal range is ≥ 2.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `transmit`  in  1  start request; sampled only while idle.
- `data`  in  8  byte to send; captured on the accepting edge.
- `tx`  out  1  serial line; idles high.
- `tx_idle`  out  1  high when ready to accept a byte.
- `tx_done`  out  1  one-cycle pulse when a frame's stop bit completes.

## Operation
- All outputs are registered.
- Reset values: `tx`=1, `tx_idle`=1, `tx_done`=0, state IDLE, bit counter 0, baud counter 0, shift register 0.
- Asserting `rst` mid-frame aborts the frame immediately. `tx` returns high asynchronously and no `tx_done` is issued.
- States:
  - IDLE: `tx`=1, `tx_idle`=1. If `transmit`=1, latch `data` into the shift register, set `tx`=0 and `tx_idle`=0, and go to START.
  - START: hold `tx`=0 for CLKS_PER_BIT cycles. Then drive `tx`=shreg[0] and go to DATA.
  - DATA: each bit is held CLKS_PER_BIT cycles. The shift register shifts right, and the bit counter (3 bits) increments per bit. After bit 7, drive `tx`=1 and go to STOP.
  - STOP: hold `tx`=1 for CLKS_PER_BIT cycles. Then go to IDLE with `tx_idle`=1 and `tx_done`=1 for exactly one cycle.
- Baud counter width is $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1, then wraps to 0 on each bit boundary. There is no free-running baud tick; the counter restarts at every accepted frame.
- `transmit` and `data` are don't-care outside IDLE. A request while busy is dropped, not queued. Changes to `data` mid-frame do not affect the frame.
- If `transmit` is held high continuously, frames go back-to-back. The block spends exactly one IDLE cycle (line high) between the end of the stop bit and the next start bit.
- `tx_done` and acceptance of a new byte can occur in the same cycle. That IDLE cycle shows `tx_done`=1 while sampling `transmit`.

## Timing
- Let N = CLKS_PER_BIT and let edge k be the edge that samples `transmit`=1 with `tx_idle`=1.
- After edge k: `tx`=0 and `tx_idle`=0.
- After edge k+N·(1+i): `tx`=data[i], for i=0..7.
- After edge k+9N: `tx`=1 (stop bit).
- After edge k+10N: `tx_idle`=1 and `tx_done`=1. `tx_done` drops after edge k+10N+1 unless the next frame also completes then (it cannot, since N ≥ 2).
- Frame length on the line: start-bit falling edge to stop-bit end is 10N cycles. Accept-to-next-accept minimum period is 10N+1 cycles.
- Latency from `transmit` sampled to the start bit on `tx`: one edge.

## Test plan
- Reset: assert `rst` asynchronously between edges. Required: `tx`=1, `tx_idle`=1, `tx_done`=0 immediately and held; no line activity while `transmit`=0 after release.
- Single byte, N=4: pulse `transmit` with `data`=0xA5. Required: `tx` sequence 0,1,0,1,0,0,1,0,1,1, each level 4 cycles; `tx_done` is a single 1-cycle pulse at cycle 40 after acceptance; `tx_idle` is low for exactly 40 cycles.
- Back-to-back, N=4: hold `transmit`=1 and present 0x00 then 0xFF. Required: two frames separated by exactly one high cycle; the second frame carries 0xFF; two `tx_done` pulses 41 cycles apart.
- Busy immunity, N=4: accept 0x3C, then mid-frame pulse `transmit` and change `data` to 0xC3. Required: the line carries 0x3C only; exactly one `tx_done`; no second frame.
- Reset mid-frame, N=4: accept 0xF0, then assert `rst` during bit 5. Required: `tx`=1 at once, no `tx_done`. After release, a new request for 0x81 produces a clean full frame.
- Minimum divisor, N=2: send 0x55 then 0x01. Required: correct bit order, 2 cycles per bit, and each `tx_done` exactly 20 cycles after its accept.

Source files
------------

// File: rtl/uart_tx_byte.sv
// Byte-level 8N1 UART transmitter, LSB first. Accepts a byte while idle,
// frames it as start/8 data/stop and pulses tx_done when the stop bit ends.
module uart_tx_byte #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       transmit,
   input  logic [7:0] data,
   output logic       tx,
   output logic       tx_idle,
   output logic       tx_done
);

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

   state_e        state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          tx_q, tx_d;
   logic          idle_q, idle_d;
   logic          done_q, done_d;
   logic          bit_end;

   assign tx      = tx_q;
   assign tx_idle = idle_q;
   assign tx_done = done_q;
   assign bit_end = (baud_q == BAUD_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         tx_q    <= 1'b1;
         idle_q  <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         tx_q    <= tx_d;
         idle_q  <= idle_d;
         done_q  <= done_d;
      end
   end

   // Every bit boundary restarts the baud counter; between boundaries it just counts.
   always_comb begin
      state_d = state_q;
      baud_d  = bit_end ? '0 : baud_q + 1'b1;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      tx_d    = tx_q;
      idle_d  = idle_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            baud_d = '0;
            tx_d   = 1'b1;
            idle_d = 1'b1;
            if (transmit) begin
               shreg_d = data;
               bit_d   = '0;
               tx_d    = 1'b0;
               idle_d  = 1'b0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               tx_d    = shreg_q[0];
               shreg_d = {1'b0, shreg_q[7:1]};
               bit_d   = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = S_STOP;
               end else begin
                  tx_d    = shreg_q[0];
                  shreg_d = {1'b0, shreg_q[7:1]};
               end
            end
         end
         S_STOP: begin
            if (bit_end) begin
               idle_d  = 1'b1;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            idle_d  = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_byte.sv
// Bench for uart_tx_byte: two instances (N=4 and N=2); expected line levels
// are queued per cycle when a byte is requested and popped as the line is sampled.
module tb_uart_tx_byte;

   logic       clk = 1'b0;
   logic       rst;
   logic       tr4, tr2;
   logic [7:0] d4, d2;
   logic       tx4, idle4, done4, tx2, idle2, done2;

   int   nchk = 0;
   int   nfail = 0;
   logic exp_q[$];

   always #5 clk = ~clk;

   uart_tx_byte #(.CLKS_PER_BIT(4)) u4 (
      .clk(clk), .rst(rst), .transmit(tr4), .data(d4),
      .tx(tx4), .tx_idle(idle4), .tx_done(done4));

   uart_tx_byte #(.CLKS_PER_BIT(2)) u2 (
      .clk(clk), .rst(rst), .transmit(tr2), .data(d2),
      .tx(tx2), .tx_idle(idle2), .tx_done(done2));

   // Scoreboard push: one expected line level per clock for a whole frame
   task automatic push_frame(input logic [7:0] b, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(1'b0);
      for (int j = 0; j < 8; j++)
         for (int i = 0; i < n; i++) exp_q.push_back(b[j]);
      for (int i = 0; i < n; i++) exp_q.push_back(1'b1);
   endtask

   task automatic test_reset();
      rst = 1'b1; tr4 = 1'b0; tr2 = 1'b0; d4 = '0; d2 = '0;
      repeat (2) @(negedge clk);
      nchk++;
      if ({tx4, idle4, done4, tx2, idle2, done2} !== 6'b110110) begin
         nfail++; $display("FAIL reset_hold: got %b want 110110", {tx4, idle4, done4, tx2, idle2, done2});
      end
      rst = 1'b0;
      for (int t = 0; t < 8; t++) begin
         @(negedge clk);
         nchk++;
         if ({tx4, idle4, done4, tx2, idle2, done2} !== 6'b110110) begin
            nfail++; $display("FAIL reset_quiet t=%0d: got %b want 110110", t, {tx4, idle4, done4, tx2, idle2, done2});
         end
      end
      @(posedge clk); #2 rst = 1'b1; #1;
      nchk++;
      if ({tx4, idle4, done4} !== 3'b110) begin
         nfail++; $display("FAIL reset_async: got %b want 110", {tx4, idle4, done4});
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_single_byte();
      logic etx;
      @(negedge clk); d4 = 8'hA5; tr4 = 1'b1; push_frame(8'hA5, 4);
      @(negedge clk); tr4 = 1'b0; d4 = 8'h00;
      for (int t = 0; t <= 41; t++) begin
         etx = (t < 40) ? exp_q.pop_front() : 1'b1;
         nchk++;
         if ({tx4, idle4, done4} !== {etx, t >= 40, t == 40}) begin
            nfail++; $display("FAIL single_a5 t=%0d: got tx/idle/done %b want %b", t, {tx4, idle4, done4}, {etx, t >= 40, t == 40});
         end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      logic etx;
      int   dt[$];
      d4 = 8'h00; tr4 = 1'b1;
      push_frame(8'h00, 4); exp_q.push_back(1'b1); push_frame(8'hFF, 4);
      @(negedge clk); d4 = 8'hFF;
      for (int t = 0; t <= 82; t++) begin
         etx = (t < 81) ? exp_q.pop_front() : 1'b1;
         nchk++;
         if ({tx4, idle4, done4} !== {etx, t == 40 || t >= 81, t == 40 || t == 81}) begin
            nfail++; $display("FAIL b2b t=%0d: got tx/idle/done %b want %b", t, {tx4, idle4, done4}, {etx, t == 40 || t >= 81, t == 40 || t == 81});
         end
         if (done4) dt.push_back(t);
         if (t == 41) tr4 = 1'b0;
         @(negedge clk);
      end
      nchk++;
      if (dt.size() != 2 || dt[1] - dt[0] != 41) begin
         nfail++; $display("FAIL b2b_done_spacing: got %0d pulses, want 2 pulses 41 apart", dt.size());
      end
   endtask

   task automatic test_busy_immunity();
      logic etx;
      int   ndone = 0;
      d4 = 8'h3C; tr4 = 1'b1; push_frame(8'h3C, 4);
      @(negedge clk); tr4 = 1'b0;
      for (int t = 0; t <= 85; t++) begin
         etx = (t < 40) ? exp_q.pop_front() : 1'b1;
         nchk++;
         if ({tx4, idle4, done4} !== {etx, t >= 40, t == 40}) begin
            nfail++; $display("FAIL busy t=%0d: got tx/idle/done %b want %b", t, {tx4, idle4, done4}, {etx, t >= 40, t == 40});
         end
         if (done4) ndone++;
         if (t == 15) begin tr4 = 1'b1; d4 = 8'hC3; end
         if (t == 16) tr4 = 1'b0;
         @(negedge clk);
      end
      nchk++;
      if (ndone != 1) begin
         nfail++; $display("FAIL busy_done_count: got %0d want 1", ndone);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic etx;
      d4 = 8'hF0; tr4 = 1'b1; push_frame(8'hF0, 4);
      @(negedge clk); tr4 = 1'b0;
      for (int t = 0; t < 25; t++) begin
         etx = exp_q.pop_front();
         nchk++;
         if ({tx4, idle4, done4} !== {etx, 2'b00}) begin
            nfail++; $display("FAIL midrst_pre t=%0d: got %b want %b", t, {tx4, idle4, done4}, {etx, 2'b00});
         end
         @(negedge clk);
      end
      exp_q.delete();
      #2 rst = 1'b1; #1;
      nchk++;
      if ({tx4, idle4, done4} !== 3'b110) begin
         nfail++; $display("FAIL midrst_async: got %b want 110", {tx4, idle4, done4});
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int t = 0; t < 12; t++) begin
         @(negedge clk);
         nchk++;
         if ({tx4, idle4, done4} !== 3'b110) begin
            nfail++; $display("FAIL midrst_quiet t=%0d: got %b want 110", t, {tx4, idle4, done4});
         end
      end
      d4 = 8'h81; tr4 = 1'b1; push_frame(8'h81, 4);
      @(negedge clk); tr4 = 1'b0;
      for (int t = 0; t <= 41; t++) begin
         etx = (t < 40) ? exp_q.pop_front() : 1'b1;
         nchk++;
         if ({tx4, idle4, done4} !== {etx, t >= 40, t == 40}) begin
            nfail++; $display("FAIL midrst_81 t=%0d: got %b want %b", t, {tx4, idle4, done4}, {etx, t >= 40, t == 40});
         end
         @(negedge clk);
      end
   endtask

   task automatic test_min_divisor();
      logic etx;
      int   dt[$];
      d2 = 8'h55; tr2 = 1'b1;
      push_frame(8'h55, 2); exp_q.push_back(1'b1); push_frame(8'h01, 2);
      @(negedge clk); tr2 = 1'b0;
      for (int t = 0; t <= 42; t++) begin
         etx = (t < 41) ? exp_q.pop_front() : 1'b1;
         nchk++;
         if ({tx2, idle2, done2} !== {etx, t == 20 || t >= 41, t == 20 || t == 41}) begin
            nfail++; $display("FAIL n2 t=%0d: got tx/idle/done %b want %b", t, {tx2, idle2, done2}, {etx, t == 20 || t >= 41, t == 20 || t == 41});
         end
         if (done2) dt.push_back(t);
         if (t == 20) begin tr2 = 1'b1; d2 = 8'h01; end
         if (t == 21) tr2 = 1'b0;
         @(negedge clk);
      end
      nchk++;
      if (dt.size() != 2 || dt[1] - dt[0] != 21) begin
         nfail++; $display("FAIL n2_done_spacing: got %0d pulses, want 2 pulses 21 apart", dt.size());
      end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_busy_immunity();
      test_reset_mid_frame();
      test_min_divisor();
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
